axi_txn_drain_ctrl: RTL and testbench
=====================================

# axi_txn_drain_ctrl

Handshake-level controller placed in front of the AXI ID serializer on the FPGA block design. It caps outstanding write and read transactions at configurable limits by gating the AW/AR valid/ready pairs, and counts B and R-last completions. It also sequences a drain handshake (quiesce, then report idle) so the serializer and downstream interconnect can be safely reconfigured or reset. Payload signals bypass this block; only handshake signals pass through it.

## Interface
- MAX_WRITE_TXNS, 32'd8, write transactions (AW accepted, B not yet accepted) allowed in flight; legal range 1..255
- MAX_READ_TXNS, 32'd8, read transactions (AR accepted, last R not yet accepted) allowed in flight; legal range 1..255
- aclk  in  1  clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- s_axi_awvalid  in  1  upstream AW valid
- s_axi_awready  out  1  upstream AW ready
- m_axi_awvalid  out  1  downstream AW valid, toward the serializer
- m_axi_awready  in  1  downstream AW ready
- s_axi_arvalid  in  1  upstream AR valid
- s_axi_arready  out  1  upstream AR ready
- m_axi_arvalid  out  1  downstream AR valid
- m_axi_arready  in  1  downstream AR ready
- axi_bvalid, axi_bready  in  1 each  monitored B handshake on the upstream side
- axi_rvalid, axi_rready, axi_rlast  in  1 each  monitored R handshake on the upstream side
- drain_req  in  1  level request to quiesce
- idle  out  1  drained; no transaction in flight, no new ones admitted
- wr_outstanding  out  8  current write count
- rd_outstanding  out  8  current read count
- err_underflow  out  1  sticky; a completion arrived with its counter at 0

## Operation
- Admit (AW): allow_aw = aw_hold | (state==RUN & wr_cnt < MAX_WRITE_TXNS).
  - m_axi_awvalid = s_axi_awvalid & allow_aw.
  - s_axi_awready = m_axi_awready & allow_aw.
  - AR path is identical, using ar_hold, rd_cnt and MAX_READ_TXNS.
- AXI stability: aw_hold sets when m_axi_awvalid & !m_axi_awready and clears on the AW handshake. While it is set, the gate stays open regardless of limit or state, so an asserted valid is never withdrawn. ar_hold works the same way.
- Counters, per direction, 8 bits:
  - +1 on a downstream A-channel handshake.
  - −1 on a completion: B handshake for writes; R handshake with rlast for reads.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - A decrement at 0 saturates at 0 and sets err_underflow, which is cleared only by reset.
  - The counter never exceeds its MAX.
- W channel is not gated; it passes outside this block.
- State machine (states live in the shared package):
  - RUN -> DRAIN when drain_req = 1.
  - DRAIN -> IDLE when wr_cnt==0 & rd_cnt==0 & !aw_hold & !ar_hold.
  - DRAIN -> RUN when drain_req drops before that condition is met.
  - IDLE -> RUN when drain_req = 0.
  - In DRAIN and IDLE, no new AW/AR is admitted; held transfers still complete.
- idle = (state==IDLE), registered.

## Timing
- Gating is combinational: zero-cycle valid/ready latency through the block.
- Counter and outstanding outputs update on the clock edge after the handshake.
- idle asserts 1 cycle after the last completion that drains both counters, provided drain_req is held. It deasserts 1 cycle after drain_req falls.
- Reset values: state RUN; wr_cnt, rd_cnt, wr_outstanding, rd_outstanding = 0; aw_hold, ar_hold = 0; idle = 0; err_underflow = 0. Gated outputs follow their inputs through allow_* immediately.
- Limit boundary: with cnt==MAX and a completion in the same cycle, the gate stays closed that cycle and opens the next.
- drain_req rising in the same cycle as an AW handshake: that handshake completes and is counted. The gate closes from the next cycle.
- Reset asserted mid-transaction clears all state immediately. Later completions for pre-reset transactions trigger err_underflow by design.

## Structure
- axi_txn_drain_ctrl_pkg holds:
  - drain_state_e enum {RUN, DRAIN, IDLE}
  - the 8-bit count typedef
  - a MAX_TXNS_LIMIT = 255 constant, used for parameter elaboration checks
- Sub-module axi_txn_counter, instantiated twice: inc, dec, limit in; count, at_limit, underflow out.
- Top level holds the hold flags, gating logic and FSM.

## Test plan
- MAX_WRITE_TXNS=2, downstream ready always 1, three back-to-back AW with no B -> first two pass; third sees s_axi_awready=0 and wr_outstanding=2. One B -> third passes the next cycle.
- m_axi_awready=0 for 5 cycles, then drain_req=1 on cycle 2 -> m_axi_awvalid stays 1 through the handshake and wr_outstanding becomes 1.
- 2 reads in flight, drain_req=1, then R bursts of 4 beats each -> counter drops only on rlast beats, and idle=1 one cycle after the second rlast. drain_req=0 -> idle=0 next cycle and AR is admitted again.
- Same-cycle AR handshake and rlast completion at rd_cnt=3 -> rd_outstanding stays 3.
- B handshake with wr_cnt=0 -> err_underflow=1 and wr_outstanding=0. The flag stays set until rstn is pulsed low asynchronously mid-cycle, which clears all outputs.

Source files
------------

// File: rtl/axi_txn_drain_ctrl_pkg.sv
// Shared types and constants for the AXI transaction drain controller.
package axi_txn_drain_ctrl_pkg;

  localparam int unsigned CNT_W          = 8;
  localparam int unsigned MAX_TXNS_LIMIT = 255;

  typedef logic [CNT_W-1:0] txn_cnt_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } drain_state_e;

  // A per-direction limit of zero would deadlock the gate; above 255 overflows the counter.
  function automatic bit txn_limit_ok(input int unsigned n);
    return (n >= 1) && (n <= MAX_TXNS_LIMIT);
  endfunction

endpackage

// File: rtl/axi_txn_drain_ctrl_if.sv
// AW/AR gated handshakes plus monitored B/R handshakes seen by the drain controller.
interface axi_txn_drain_ctrl_if;

  logic s_axi_awvalid;
  logic s_axi_awready;
  logic m_axi_awvalid;
  logic m_axi_awready;

  logic s_axi_arvalid;
  logic s_axi_arready;
  logic m_axi_arvalid;
  logic m_axi_arready;

  logic axi_bvalid;
  logic axi_bready;
  logic axi_rvalid;
  logic axi_rready;
  logic axi_rlast;

  modport slave (
    input  s_axi_awvalid, m_axi_awready,
    input  s_axi_arvalid, m_axi_arready,
    input  axi_bvalid, axi_bready,
    input  axi_rvalid, axi_rready, axi_rlast,
    output s_axi_awready, m_axi_awvalid,
    output s_axi_arready, m_axi_arvalid
  );

  modport master (
    output s_axi_awvalid, m_axi_awready,
    output s_axi_arvalid, m_axi_arready,
    output axi_bvalid, axi_bready,
    output axi_rvalid, axi_rready, axi_rlast,
    input  s_axi_awready, m_axi_awvalid,
    input  s_axi_arready, m_axi_arvalid
  );

endinterface

// File: rtl/axi_txn_counter.sv
// Saturating outstanding-transaction counter with limit compare and underflow event.
module axi_txn_counter
  import axi_txn_drain_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc,
  input  logic     dec,
  input  txn_cnt_t limit,
  output txn_cnt_t count,
  output logic     at_limit,
  output logic     underflow
);

  txn_cnt_t count_next;

  // Simultaneous inc/dec cancel; a lone dec at zero is flagged and ignored.
  always_comb begin
    count_next = count;
    underflow  = 1'b0;
    if (inc && !dec) begin
      if (count < limit) begin
        count_next = count + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      if (count == '0) begin
        underflow = 1'b1;
      end else begin
        count_next = count - CNT_W'(1);
      end
    end
  end

  assign at_limit = (count >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/axi_txn_drain_ctrl.sv
// Caps outstanding AXI writes/reads by gating AW/AR handshakes and sequences a drain-to-idle handshake.
module axi_txn_drain_ctrl
  import axi_txn_drain_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WRITE_TXNS = 32'd8,
  parameter int unsigned MAX_READ_TXNS  = 32'd8
)(
  input  logic                  aclk,
  input  logic                  rstn,
  axi_txn_drain_ctrl_if.slave   axi,
  input  logic                  drain_req,
  output logic                  idle,
  output txn_cnt_t              wr_outstanding,
  output txn_cnt_t              rd_outstanding,
  output logic                  err_underflow
);

  if (!txn_limit_ok(MAX_WRITE_TXNS)) begin : g_bad_wr_limit
    $error("MAX_WRITE_TXNS must be in 1..%0d", MAX_TXNS_LIMIT);
  end
  if (!txn_limit_ok(MAX_READ_TXNS)) begin : g_bad_rd_limit
    $error("MAX_READ_TXNS must be in 1..%0d", MAX_TXNS_LIMIT);
  end

  localparam txn_cnt_t WR_LIMIT = CNT_W'(MAX_WRITE_TXNS);
  localparam txn_cnt_t RD_LIMIT = CNT_W'(MAX_READ_TXNS);

  drain_state_e state, state_next;
  logic         aw_hold, aw_hold_next;
  logic         ar_hold, ar_hold_next;
  logic         allow_aw, allow_ar;
  logic         aw_hs, ar_hs, b_hs, r_done;
  logic         wr_at_limit, rd_at_limit;
  logic         wr_uf, rd_uf;
  logic         drained;
  txn_cnt_t     wr_cnt, rd_cnt;

  // Gate: a valid already presented downstream stays admitted until it handshakes.
  assign allow_aw = aw_hold | ((state == RUN) & !wr_at_limit);
  assign allow_ar = ar_hold | ((state == RUN) & !rd_at_limit);

  assign axi.m_axi_awvalid = axi.s_axi_awvalid & allow_aw;
  assign axi.s_axi_awready = axi.m_axi_awready & allow_aw;
  assign axi.m_axi_arvalid = axi.s_axi_arvalid & allow_ar;
  assign axi.s_axi_arready = axi.m_axi_arready & allow_ar;

  assign aw_hs  = axi.m_axi_awvalid & axi.m_axi_awready;
  assign ar_hs  = axi.m_axi_arvalid & axi.m_axi_arready;
  assign b_hs   = axi.axi_bvalid & axi.axi_bready;
  assign r_done = axi.axi_rvalid & axi.axi_rready & axi.axi_rlast;

  axi_txn_counter u_wr_cnt (
    .clk       (aclk),
    .rst_n     (rstn),
    .inc       (aw_hs),
    .dec       (b_hs),
    .limit     (WR_LIMIT),
    .count     (wr_cnt),
    .at_limit  (wr_at_limit),
    .underflow (wr_uf)
  );

  axi_txn_counter u_rd_cnt (
    .clk       (aclk),
    .rst_n     (rstn),
    .inc       (ar_hs),
    .dec       (r_done),
    .limit     (RD_LIMIT),
    .count     (rd_cnt),
    .at_limit  (rd_at_limit),
    .underflow (rd_uf)
  );

  assign wr_outstanding = wr_cnt;
  assign rd_outstanding = rd_cnt;

  // Stalled-valid tracking so the gate never withdraws a presented request.
  always_comb begin
    aw_hold_next = aw_hold;
    ar_hold_next = ar_hold;
    if (aw_hs) begin
      aw_hold_next = 1'b0;
    end else if (axi.m_axi_awvalid) begin
      aw_hold_next = 1'b1;
    end
    if (ar_hs) begin
      ar_hold_next = 1'b0;
    end else if (axi.m_axi_arvalid) begin
      ar_hold_next = 1'b1;
    end
  end

  // Both counters reach zero at this edge: looks through a same-cycle final completion so
  // idle can rise one cycle after it. In DRAIN no unheld A-channel handshake can occur.
  assign drained = !aw_hold && !ar_hold &&
                   ((wr_cnt == '0) || ((wr_cnt == CNT_W'(1)) && b_hs)) &&
                   ((rd_cnt == '0) || ((rd_cnt == CNT_W'(1)) && r_done));

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (drain_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (!drain_req)   state_next = RUN;
        else if (drained) state_next = IDLE;
      end
      IDLE: begin
        if (!drain_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state         <= RUN;
      aw_hold       <= 1'b0;
      ar_hold       <= 1'b0;
      idle          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_next;
      aw_hold       <= aw_hold_next;
      ar_hold       <= ar_hold_next;
      idle          <= (state_next == IDLE);
      err_underflow <= err_underflow | wr_uf | rd_uf;
    end
  end

endmodule

// File: tb/tb_axi_txn_drain_ctrl.sv
// Vector-table bench for axi_txn_drain_ctrl with a queue of post-edge expectations.
module tb_axi_txn_drain_ctrl;
  import axi_txn_drain_ctrl_pkg::*;

  logic     aclk;
  logic     rstn;
  logic     drain_req;
  logic     idle;
  txn_cnt_t wr_outstanding;
  txn_cnt_t rd_outstanding;
  logic     err_underflow;

  axi_txn_drain_ctrl_if bus ();

  axi_txn_drain_ctrl #(
    .MAX_WRITE_TXNS (32'd2),
    .MAX_READ_TXNS  (32'd4)
  ) dut (
    .aclk           (aclk),
    .rstn           (rstn),
    .axi            (bus),
    .drain_req      (drain_req),
    .idle           (idle),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .err_underflow  (err_underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // in:  {awvalid, m_awready, arvalid, m_arready, bvalid, bready, rvalid, rready, rlast, drain_req}
  // g:   {s_awready, m_awvalid, s_arready, m_arvalid} during the cycle
  // wr/rd/idl/err: registered outputs after the clock edge
  typedef struct {
    string      tag;
    logic [9:0] in;
    logic [3:0] g;
    int         wr;
    int         rd;
    logic       idl;
    logic       err;
  } vec_t;

  typedef struct {
    string tag;
    int    wr;
    int    rd;
    logic  idl;
    logic  err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string tag, input logic [9:0] in, input logic [3:0] g,
                              input int wr, input int rd, input logic idl, input logic err);
    vec_t v;
    v.tag = tag; v.in = in; v.g = g; v.wr = wr; v.rd = rd; v.idl = idl; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [9:0] in);
    {bus.s_axi_awvalid, bus.m_axi_awready, bus.s_axi_arvalid, bus.m_axi_arready,
     bus.axi_bvalid, bus.axi_bready, bus.axi_rvalid, bus.axi_rready, bus.axi_rlast,
     drain_req} = in;
  endtask

  // Called at posedge+1: drive, check gates mid-cycle, check registered state after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    set_inputs(v.in);
    sb.push_back('{v.tag, v.wr, v.rd, v.idl, v.err});
    @(negedge aclk);
    chk({v.tag, ".s_awready"}, int'(bus.s_axi_awready), int'(v.g[3]));
    chk({v.tag, ".m_awvalid"}, int'(bus.m_axi_awvalid), int'(v.g[2]));
    chk({v.tag, ".s_arready"}, int'(bus.s_axi_arready), int'(v.g[1]));
    chk({v.tag, ".m_arvalid"}, int'(bus.m_axi_arvalid), int'(v.g[0]));
    @(posedge aclk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", v.tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".wr_outstanding"}, int'(wr_outstanding), e.wr);
      chk({e.tag, ".rd_outstanding"}, int'(rd_outstanding), e.rd);
      chk({e.tag, ".idle"},           int'(idle),           int'(e.idl));
      chk({e.tag, ".err_underflow"},  int'(err_underflow),  int'(e.err));
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_outstanding"}, int'(wr_outstanding), 0);
    chk({tag, ".rd_outstanding"}, int'(rd_outstanding), 0);
    chk({tag, ".idle"},           int'(idle),           0);
    chk({tag, ".err_underflow"},  int'(err_underflow),  0);
  endtask

  initial begin
    rstn = 1'b0;
    set_inputs(10'b0);
    #2;
    // In reset the gate is open (RUN, counts 0) and passes handshakes straight through.
    set_inputs(10'b11_11_00_000_0);
    #1;
    chk_all_zero("RST");
    chk("RST.m_awvalid", int'(bus.m_axi_awvalid), 1);
    chk("RST.s_awready", int'(bus.s_axi_awready), 1);
    chk("RST.m_arvalid", int'(bus.m_axi_arvalid), 1);
    chk("RST.s_arready", int'(bus.s_axi_arready), 1);
    set_inputs(10'b0);
    @(negedge aclk);
    rstn = 1'b1;
    @(posedge aclk);
    #1;

    // Write limit of 2 and the limit-boundary completion.
    tbl.push_back(mk("A1", 10'b11_00_00_000_0, 4'b1100, 1, 0, 0, 0));
    tbl.push_back(mk("A2", 10'b11_00_00_000_0, 4'b1100, 2, 0, 0, 0));
    tbl.push_back(mk("A3", 10'b11_00_00_000_0, 4'b0000, 2, 0, 0, 0));
    tbl.push_back(mk("A4", 10'b11_00_11_000_0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("A5", 10'b11_00_00_000_0, 4'b1100, 2, 0, 0, 0));
    tbl.push_back(mk("A6", 10'b00_00_11_000_0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("A7", 10'b00_00_11_000_0, 4'b0000, 0, 0, 0, 0));
    // Stalled AW held open across a drain request, then drain completes to idle.
    tbl.push_back(mk("B1", 10'b10_00_00_000_0, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("B2", 10'b10_00_00_000_1, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("B3", 10'b10_00_00_000_1, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("B4", 10'b10_00_00_000_1, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("B5", 10'b10_00_00_000_1, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("B6", 10'b11_00_00_000_1, 4'b1100, 1, 0, 0, 0));
    tbl.push_back(mk("B7", 10'b11_00_00_000_1, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("B8", 10'b00_00_11_000_1, 4'b0000, 0, 0, 1, 0));
    tbl.push_back(mk("B9", 10'b11_00_00_000_1, 4'b0000, 0, 0, 1, 0));
    tbl.push_back(mk("B10", 10'b00_00_00_000_0, 4'b0000, 0, 0, 0, 0));
    // Two reads drained by 4-beat bursts; only rlast handshakes decrement.
    tbl.push_back(mk("C1", 10'b00_11_00_000_0, 4'b0011, 0, 1, 0, 0));
    tbl.push_back(mk("C2", 10'b00_11_00_000_0, 4'b0011, 0, 2, 0, 0));
    tbl.push_back(mk("C3", 10'b00_00_00_000_1, 4'b0000, 0, 2, 0, 0));
    tbl.push_back(mk("C4", 10'b00_11_00_110_1, 4'b0000, 0, 2, 0, 0));
    tbl.push_back(mk("C5", 10'b00_00_00_110_1, 4'b0000, 0, 2, 0, 0));
    tbl.push_back(mk("C6", 10'b00_00_00_110_1, 4'b0000, 0, 2, 0, 0));
    tbl.push_back(mk("C7", 10'b00_00_00_111_1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk("C8", 10'b00_00_00_101_1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk("C9", 10'b00_00_00_110_1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk("C10", 10'b00_00_00_110_1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk("C11", 10'b00_00_00_110_1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk("C12", 10'b00_00_00_111_1, 4'b0000, 0, 0, 1, 0));
    tbl.push_back(mk("C13", 10'b00_11_00_000_0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk("C14", 10'b00_11_00_000_0, 4'b0011, 0, 1, 0, 0));
    // Same-cycle AR + rlast at 3, then read limit of 4 with a boundary completion.
    tbl.push_back(mk("D1", 10'b00_11_00_000_0, 4'b0011, 0, 2, 0, 0));
    tbl.push_back(mk("D2", 10'b00_11_00_000_0, 4'b0011, 0, 3, 0, 0));
    tbl.push_back(mk("D3", 10'b00_11_00_111_0, 4'b0011, 0, 3, 0, 0));
    tbl.push_back(mk("D4", 10'b00_11_00_000_0, 4'b0011, 0, 4, 0, 0));
    tbl.push_back(mk("D5", 10'b00_11_00_000_0, 4'b0000, 0, 4, 0, 0));
    tbl.push_back(mk("D6", 10'b00_11_00_111_0, 4'b0000, 0, 3, 0, 0));
    tbl.push_back(mk("D7", 10'b00_00_00_111_0, 4'b0000, 0, 2, 0, 0));
    tbl.push_back(mk("D8", 10'b00_00_00_111_0, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk("D9", 10'b00_00_00_111_0, 4'b0000, 0, 0, 0, 0));
    // Underflow is sticky; then leave one write and one read in flight.
    tbl.push_back(mk("E1", 10'b00_00_11_000_0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk("E2", 10'b00_00_00_000_0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk("E3", 10'b00_00_00_111_0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk("E4", 10'b11_00_00_000_0, 4'b1100, 1, 0, 0, 1));
    tbl.push_back(mk("E5", 10'b00_11_00_000_0, 4'b0011, 1, 1, 0, 1));
    run_table();

    // Asynchronous reset pulsed mid-cycle clears everything without waiting for a clock edge.
    set_inputs(10'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("RST2");
    @(negedge aclk);
    rstn = 1'b1;
    @(posedge aclk);
    #1;
    chk_all_zero("RST2.post");

    // Drain rising with an AW handshake, drain aborted before quiescence, late completions.
    tbl.push_back(mk("F1", 10'b11_00_00_000_1, 4'b1100, 1, 0, 0, 0));
    tbl.push_back(mk("F2", 10'b11_00_00_000_1, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("F3", 10'b00_00_11_000_1, 4'b0000, 0, 0, 1, 0));
    tbl.push_back(mk("F4", 10'b00_00_00_000_0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk("F5", 10'b11_00_00_000_0, 4'b1100, 1, 0, 0, 0));
    tbl.push_back(mk("F6", 10'b00_00_00_000_1, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("F7", 10'b11_00_00_000_0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("F8", 10'b11_00_00_000_0, 4'b1100, 2, 0, 0, 0));
    tbl.push_back(mk("F9", 10'b00_00_11_000_0, 4'b0000, 1, 0, 0, 0));
    tbl.push_back(mk("F10", 10'b00_00_11_000_0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk("G1", 10'b00_00_11_000_0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk("G2", 10'b00_00_00_111_0, 4'b0000, 0, 0, 0, 1));
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
